// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the 8-way round-robin mux arbiter.
package mux8_rr_arbiter_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT
    } state_t;

    localparam int NUM_REQ = 8;

    // Burst counter width; a one-word burst still needs a 1-bit counter.
    function automatic int cnt_width(input int max_burst);
        return (max_burst <= 2) ? 1 : $clog2(max_burst);
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Requester/consumer bundle of the round-robin mux arbiter.
interface mux8_rr_arbiter_if #(
    parameter int N = 32
);
    logic [7:0]     req;
    logic [8*N-1:0] data_in;
    logic [7:0]     ack;
    logic [7:0]     gnt;
    logic [2:0]     sel;
    logic [N-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           busy;

    // Producers and the consumer side.
    modport master (
        output req, data_in, out_ready,
        input  ack, gnt, sel, out_data, out_valid, busy
    );

    // The arbiter itself.
    modport slave (
        input  req, data_in, out_ready,
        output ack, gnt, sel, out_data, out_valid, busy
    );
endinterface

// File: rtl/mux8_rr_arbiter_mux_8to1.sv
// Plain 8:1 word mux used as the shared datapath.
module mux_8to1 #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_data [8],
    input  logic [2:0]   i_sel,
    output logic [N-1:0] o_data
);

    assign o_data = i_data[i_sel];

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux among eight requesters, with
// bursts of up to MAX_BURST words per grant.
//
// state | meaning
// IDLE  | no grant held, waiting for any request
// GRANT | r_sel owns the mux; transfers counted in r_cnt
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int N         = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rstb,
    mux8_rr_arbiter_if.slave bus
);

    localparam int            CW       = cnt_width(MAX_BURST);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_gnt, w_gnt_nxt;
    logic [2:0]    r_sel, w_sel_nxt;
    logic [2:0]    r_ptr, w_ptr_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    logic          w_req_sel;
    logic          w_out_valid;
    logic          w_xfer;
    logic          w_release;
    logic          w_found;
    logic [2:0]    w_base;
    logic [2:0]    w_win;
    logic [N-1:0]  w_slices [8];

    assign w_req_sel   = bus.req[r_sel];
    assign w_out_valid = (r_state == GRANT) && w_req_sel;
    assign w_xfer      = w_out_valid && bus.out_ready;
    assign w_release   = (r_state == GRANT) && ((w_xfer && (r_cnt == CNT_LAST)) || !w_req_sel);

    // On release the scan already starts past the releasing requester, so
    // re-arbitration happens on the same edge without a bubble.
    assign w_base = w_release ? (r_sel + 3'd1) : r_ptr;

    // Rotating priority scan: lowest offset from w_base wins, so iterate downwards.
    always_comb begin
        w_found = 1'b0;
        w_win   = w_base;
        for (int i = 7; i >= 0; i--) begin
            if (bus.req[w_base + 3'(i)]) begin
                w_found = 1'b1;
                w_win   = w_base + 3'(i);
            end
        end
    end

    // Next-state and next-grant selection.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = 8'd1 << w_win;
                    w_sel_nxt   = w_win;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_ptr_nxt = r_sel + 3'd1;
                    if (w_found) begin
                        w_gnt_nxt = 8'd1 << w_win;
                        w_sel_nxt = w_win;
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = 8'h00;
                    end
                end else if (w_xfer) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and grant registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= IDLE;
            r_gnt   <= 8'h00;
            r_sel   <= 3'd0;
            r_ptr   <= 3'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_slices[g] = bus.data_in[g*N +: N];
    end

    mux_8to1 #(.N(N)) u_mux (
        .i_data (w_slices),
        .i_sel  (r_sel),
        .o_data (bus.out_data)
    );

    assign bus.gnt       = r_gnt;
    assign bus.sel       = r_sel;
    assign bus.busy      = (r_state == GRANT);
    assign bus.out_valid = w_out_valid;
    assign bus.ack       = w_xfer ? r_gnt : 8'h00;

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one N-bit, 8-input mux datapath among 8 requesters.
- Each requester presents a request line and an N-bit word. The block grants one requester at a time, drives the 3-bit mux select, and forwards the selected word to a single valid/ready consumer.
- A granted requester keeps the grant for a burst of up to MAX_BURST transfers, then the grant rotates.
- Sits between 8 producer blocks and one shared consumer, such as a bus or register-file write port.

Parameters:
- N, 32: data width of each input word and of the output.
- MAX_BURST, 4: maximum transfers per grant; legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstb  input  1  asynchronous, active-low reset.
- req  input  8  request lines; bit i belongs to requester i.
- data_in  input  8*N  packed requester words; requester i occupies bits [i*N +: N].
- ack  output  8  one-hot; ack[i] high means requester i's word transfers this cycle.
- gnt  output  8  one-hot or zero; registered current grant.
- sel  output  3  registered mux select, equal to the index of the set gnt bit.
- out_data  output  N  word selected from data_in by sel.
- out_valid  output  1  a granted word is being presented.
- out_ready  input  1  consumer accepts out_data this cycle.
- busy  output  1  high when the state is GRANT.

Behaviour:
- Reset (rstb=0, async):
  - state=IDLE; gnt=0, sel=0, ptr=0, cnt=0.
  - out_valid=0, ack=0, busy=0 take effect immediately, not at the next edge.
  - out_data follows sel=0 (data_in[0 +: N]).
- Priority search: starting at index ptr, scan ptr, ptr+1, ..., ptr+7, all mod 8. The first index with req set wins.
- IDLE:
  - If req != 0 at edge t: gnt gets the one-hot winner, sel gets the winner index, cnt=0, state=GRANT.
  - Grant is visible in cycle t+1. Latency from request to first possible transfer is 1 cycle.
- GRANT:
  - out_valid = req[sel], combinational.
  - out_data = data_in[sel*N +: N], combinational through the mux.
  - ack = gnt when out_valid & out_ready; otherwise ack=0.
  - Transfer: out_valid & out_ready; cnt increments.
  - Stall: out_valid & ~out_ready holds grant, cnt and sel. A requester must keep its req and word stable until ack.
- Release: occurs at the edge where either of these holds:
  - (a) a transfer happens with cnt == MAX_BURST-1; or
  - (b) req[sel]==0, meaning the requester dropped or went idle.
- On release:
  - ptr = sel+1 mod 8; the scan wraps from 7 to 0.
  - The same edge re-arbitrates against the current req vector, starting from the new ptr. There is no bubble cycle between grants.
  - The releasing requester has lowest priority and is re-granted only if no other request is pending.
  - If no req bits are set, state=IDLE, gnt=0, sel unchanged.
- MAX_BURST=1: every transfer releases, giving strict per-word round-robin.
- A request asserting in the same cycle as a release is visible to that re-arbitration.
- cnt width: clog2(MAX_BURST), minimum 1 bit. cnt resets to 0 on every new grant.

Decomposition:
- Shared package:
  - State encoding localparams: IDLE=1'b0, GRANT=1'b1.
  - A function computing counter width from MAX_BURST.
- Sub-module: the existing mux_8to1 (N passed through) performs the data selection from the eight unpacked data_in slices, driven by sel.
- The priority-rotate search stays inside this block, as a combinational loop or a function.

Test Plan:
- Single requester: req=8'h04, out_ready=1, MAX_BURST=4.
  - Expect gnt=8'h04 and sel=2 one cycle after req.
  - Expect 4 acks carrying data_in[2]; then the same requester is re-granted with no idle cycle.
- All requesting: req=8'hFF, out_ready=1, MAX_BURST=1.
  - Expect grant order 0,1,2,...,7,0 with one transfer per cycle and ack rotating in step.
- Wrap-around with burst limit: req=8'h81, starting ptr=7, MAX_BURST=2.
  - Expect 7,7,0,0,7,7 grants.
  - Expect out_data to match the granted word on every ack.
- Stall: grant held on requester 5, out_ready=0 for 3 cycles.
  - Expect out_valid=1, ack=0, and unchanged sel/cnt during the stall.
  - The transfer completes on the cycle out_ready=1.
- Early drop: requester 3 granted, deasserts req after 1 of 4 transfers while req[6]=1.
  - At the next edge expect gnt=8'h40 and ptr=4.
- Reset mid-burst: rstb low mid-transfer while out_valid=1.
  - Expect out_valid, ack, gnt and busy to go 0 immediately, before any clock edge.
  - After release of rstb, arbitration restarts from ptr=0.
